// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl -- vectored interrupt controller feeding the single-cycle MIPS core.
//
// Latches rising edges on the external IRQ lines into a pending register,
// masks and prioritises them (lowest index wins), and raises a registered
// interrupt request with the handler vector of the chosen source. The request
// is held until the core acknowledges it; the source is then tracked as
// in service until the handler signals end of interrupt.
//
// Optional feature (compile-time macro INTC_NEST_EN):
//   defined   -> one level of nesting: a strictly higher-priority source may
//                preempt a running handler; the interrupted id is kept in a
//                single save register and restored on the nested eoi.
//   undefined -> no preemption; higher-priority sources wait for eoi.
//
// Ports:
//   clk        in   1        clock
//   reset      in   1        asynchronous, active-high reset
//   irq_in     in   NUM_SRC  raw requests, rising-edge sensitive
//   mask       in   NUM_SRC  1 = source masked (pending bit still latches)
//   status_bit in   1        core status, 1 = interrupts disabled
//   int_ack    in   1        core accepts the request (1-cycle pulse)
//   eoi        in   1        end of interrupt from the handler (1-cycle pulse)
//   interrupt  out  1        request to the core
//   vector     out  32       handler address of active_id, valid while interrupt=1
//   active_id  out  3        latched source id (requesting or in service)
//   pending    out  NUM_SRC  latched, un-serviced edges
//   in_service out  1        a handler is running
// -----------------------------------------------------------------------------
module intr_ctrl #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int unsigned VEC_SHIFT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               status_bit,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               interrupt,
  output logic [31:0]        vector,
  output logic [2:0]         active_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_SERVICE  = 3'd2
`ifdef INTC_NEST_EN
    ,
    ST_NEST_REQ = 3'd3,
    ST_NEST_SVC = 3'd4
`endif
  } state_t;

  // Lowest set index of v (0 when v is empty; callers qualify with |v).
  function automatic logic [2:0] first_set(input logic [NUM_SRC-1:0] v);
    logic [2:0] id;
    id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      id = v[i] ? 3'(i) : id;
    end
    return id;
  endfunction

  // Handler address for a source id; 32-bit unsigned wrap-around.
  function automatic logic [31:0] vec_of(input logic [2:0] id);
    return VEC_BASE + ({29'b0, id} << VEC_SHIFT);
  endfunction

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               interrupt_q, interrupt_d;
  logic               in_service_q, in_service_d;
  logic [2:0]         active_id_q, active_id_d;
  logic [31:0]        vector_q, vector_d;
`ifdef INTC_NEST_EN
  logic [2:0]         save_q, save_d;
`endif

  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [7:0]         mask_ext_s;
  logic [2:0]         win_id_s;
  logic               any_elig_s;
  logic               ack_clr_s;

  // Edge detection and arbitration over the registered pending bits.
  always_comb begin
    rise_s     = irq_in & ~irq_q;
    eligible_s = pending_q & ~mask;
    win_id_s   = first_set(eligible_s);
    any_elig_s = |eligible_s;
    // Zero-extended so active_id can index it for any NUM_SRC.
    mask_ext_s = 8'(mask);
  end

  // Next-state logic of the request/service FSM and its registered outputs.
  always_comb begin
    state_d      = state_q;
    interrupt_d  = interrupt_q;
    in_service_d = in_service_q;
    active_id_d  = active_id_q;
    vector_d     = vector_q;
    ack_clr_s    = 1'b0;
`ifdef INTC_NEST_EN
    save_d       = save_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_elig_s && !status_bit) begin
          state_d     = ST_REQ;
          active_id_d = win_id_s;
          vector_d    = vec_of(win_id_s);
          interrupt_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Acknowledge beats a withdraw arriving in the same cycle.
        if (int_ack) begin
          ack_clr_s    = 1'b1;
          interrupt_d  = 1'b0;
          in_service_d = 1'b1;
          state_d      = ST_SERVICE;
        end else if (status_bit || mask_ext_s[active_id_q]) begin
          interrupt_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
`ifdef INTC_NEST_EN
        end else if (any_elig_s && !status_bit && (win_id_s < active_id_q)) begin
          save_d      = active_id_q;
          active_id_d = win_id_s;
          vector_d    = vec_of(win_id_s);
          interrupt_d = 1'b1;
          state_d     = ST_NEST_REQ;
`endif
        end else begin
          state_d = ST_SERVICE;
        end
      end
`ifdef INTC_NEST_EN
      ST_NEST_REQ: begin
        if (int_ack) begin
          ack_clr_s   = 1'b1;
          interrupt_d = 1'b0;
          state_d     = ST_NEST_SVC;
        end else if (status_bit || mask_ext_s[active_id_q]) begin
          // Withdrawn preemption: resume tracking the interrupted handler.
          interrupt_d = 1'b0;
          active_id_d = save_q;
          vector_d    = vec_of(save_q);
          state_d     = ST_SERVICE;
        end else begin
          state_d = ST_NEST_REQ;
        end
      end
      ST_NEST_SVC: begin
        if (eoi) begin
          active_id_d = save_q;
          vector_d    = vec_of(save_q);
          state_d     = ST_SERVICE;
        end else begin
          state_d = ST_NEST_SVC;
        end
      end
`endif
      default: begin
        state_d      = ST_IDLE;
        interrupt_d  = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // Pending update: the acknowledged source clears, a new edge sets (set wins).
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_s[i] = ack_clr_s && (active_id_q == 3'(i));
    end
    pending_d = (pending_q & ~clr_s) | rise_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
      active_id_q  <= 3'd0;
      vector_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_in;
      pending_q    <= pending_d;
      interrupt_q  <= interrupt_d;
      in_service_q <= in_service_d;
      active_id_q  <= active_id_d;
      vector_q     <= vector_d;
    end
  end

`ifdef INTC_NEST_EN
  // Save register holding the preempted handler's id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      save_q <= 3'd0;
    end else begin
      save_q <= save_d;
    end
  end
`endif

  assign interrupt  = interrupt_q;
  assign vector     = vector_q;
  assign active_id  = active_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
